maxpool_stream: RTL and testbench
=================================

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed pixel width.
REQ-002 SHALL have parameter MAX_ROW_SIZE, default 416: maximum conv-output row length and line-buffer depth.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches config, begins one N x N plane.
REQ-006 SHALL have port ofm_size_conv  input  9  plane row length N; valid range 2..MAX_ROW_SIZE.
REQ-007 SHALL have port maxpool_mode  input  1  1 = pool, 0 = bypass.
REQ-008 SHALL have port maxpool_stride  input  2  1 or 2; other values treated as 2.
REQ-009 SHALL have port in_valid  input  1  upstream conv pixel valid.
REQ-010 SHALL have port in_data  input  DATA_WIDTH  conv pixel, row-major order.
REQ-011 SHALL have port in_ready  output  1  pixel accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse per output pixel; no backpressure.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  pooled pixel, row-major order.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last output pixel of the plane.

Function
REQ-015 SHALL implement states IDLE, RUN, EDGE, FLUSH; start in IDLE -> RUN, latching ofm_size_conv, maxpool_mode and maxpool_stride.
REQ-016 SHALL ignore start outside IDLE; config inputs are sampled only on the start cycle.
REQ-017 SHALL drive in_ready high only in RUN.
REQ-018 SHALL track accepted pixels with row/column counters 0..N-1 that wrap at N.
REQ-019 SHALL store each accepted pixel in a single-row line buffer at its column index, plus a register holding the previous pixel of the same row.
REQ-020 SHALL compare signed (two's complement), output width DATA_WIDTH, with no saturation or rounding.
REQ-021 Bypass: SHALL output each accepted pixel unchanged one cycle after the handshake; done pulses one cycle after the N*N-th output, then IDLE.
REQ-022 Stride 2: on accepting (r,c) with r and c odd, SHALL output max(lb[c-1], lb[c], prev, in) the next cycle; the last row/column is dropped when N is odd; output (N/2)^2 pixels.
REQ-023 Stride 1: SHALL output N x N pixels, out(r,c) = max over x(r..min(r+1,N-1), c..min(c+1,N-1)), i.e. right/bottom edge replication.
REQ-024 Stride 1, RUN: on accepting (r,c) with r>=1 and c>=1, SHALL output out(r-1,c-1) the next cycle.
REQ-025 Stride 1: after accepting the last pixel of row r>=1, SHALL enter EDGE for exactly one cycle (in_ready low) and emit out(r-1,N-1) = max(lb[N-1], last pixel).
REQ-026 Stride 1: after the EDGE that follows the last row, SHALL enter FLUSH and emit out(N-1,c) for c = 0..N-1, one per cycle, from the line buffer.
REQ-027 In pooling mode, done SHALL pulse on the cycle after the final out_valid; the block then returns to IDLE.
REQ-028 in_valid while in_ready is low SHALL have no effect.

Reset
REQ-029 On rst_n low, the block SHALL immediately force state IDLE, counters to 0, and in_ready, out_valid, out_data and done to 0, including mid-plane.
REQ-030 Line-buffer contents SHALL NOT be reset; no output may depend on stale contents after reset.

Configuration
REQ-031 Macro MAXPOOL_STRIDE1_EN defined: stride-1 path, EDGE and FLUSH states SHALL be compiled in per REQ-023..026.
REQ-032 Macro MAXPOOL_STRIDE1_EN undefined: the stride-1 logic, EDGE and FLUSH SHALL be absent, and maxpool_stride = 1 SHALL behave exactly as stride 2.

Verification
REQ-033 Bypass, N=4, inputs 0..15 -> 16 outputs 0..15, each one cycle after its handshake; done one cycle after output 15.
REQ-034 Stride 2, N=4, inputs 0..15 -> outputs 5, 7, 13, 15 exactly; then done.
REQ-035 Stride 2, N=2, inputs -3, -1, -7, -2 -> single output -1 (signed compare).
REQ-036 Stride 1 (macro defined), N=3, inputs 0..8 -> outputs 4, 5, 5, 7, 8, 8, 7, 8, 8; in_ready low one cycle after pixels 5 and 8; FLUSH emits the last three outputs; then done.
REQ-037 Reset after 5 accepted pixels (N=4, stride 2) -> in_ready, out_valid and done go 0 immediately; a new start followed by inputs 0..15 yields 5, 7, 13, 15.
REQ-038 Macro undefined, stride=1, N=4, inputs 0..15 -> outputs 5, 7, 13, 15; in_ready never drops mid-plane.

Source files
------------

// File: rtl/maxpool_stream.sv
// Streaming 2x2 max-pool over one N x N conv plane using a single-row line buffer.
// Optional stride-1 (edge-replicated) pooling is compiled in with MAXPOOL_STRIDE1_EN.
module maxpool_stream #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_ROW_SIZE = 416
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8:0]            ofm_size_conv,
  input  logic                  maxpool_mode,
  input  logic [1:0]            maxpool_stride,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  done,
  output logic [1:0]            dbg_state_o
);

  localparam int AW = (MAX_ROW_SIZE > 1) ? $clog2(MAX_ROW_SIZE) : 1;

`ifdef MAXPOOL_STRIDE1_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EDGE = 2'd2, FLUSH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  state_t                state_q, state_d;
  logic [8:0]            row_q, row_d;
  logic [8:0]            col_q, col_d;
  logic [8:0]            n_q, n_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  end_q, end_d;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] lb [MAX_ROW_SIZE];
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] win_max;
  logic [8:0]            n_m1;
  logic                  col_last, row_last;
  logic                  accept;
  logic                  s1_eff;

`ifdef MAXPOOL_STRIDE1_EN
  logic                  s1_q, s1_d;
  logic [8:0]            flush_idx;
  assign s1_eff    = mode_q && s1_q;
  assign flush_idx = col_last ? col_q : (col_q + 9'd1);
`else
  logic                  unused_stride;
  assign s1_eff        = 1'b0;
  assign unused_stride = ^maxpool_stride;
`endif

  // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, out_valid is never stalled.
  assign accept   = in_valid && (state_q == RUN);
  assign n_m1     = n_q - 9'd1;
  assign col_last = (col_q == n_m1);
  assign row_last = (row_q == n_m1);
  assign lb_rd    = lb[col_q[AW-1:0]];
  // left_q holds the previous row's pixel at col-1, captured before that slot was overwritten.
  assign win_max  = smax(smax(left_q, lb_rd), smax(prev_q, in_data));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    n_d         = n_q;
    mode_d      = mode_q;
    prev_d      = prev_q;
    left_d      = left_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    end_d       = 1'b0;
`ifdef MAXPOOL_STRIDE1_EN
    s1_d        = s1_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = ofm_size_conv;
          mode_d  = maxpool_mode;
`ifdef MAXPOOL_STRIDE1_EN
          s1_d    = (maxpool_stride == 2'd1);
`endif
          row_d   = 9'd0;
          col_d   = 9'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          prev_d = in_data;
          left_d = lb_rd;
          if (!mode_q) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
          end else if (s1_eff) begin
            if ((row_q != 9'd0) && (col_q != 9'd0)) begin
              out_valid_d = 1'b1;
              out_data_d  = win_max;
            end
          end else if (row_q[0] && col_q[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = win_max;
          end
          if (col_last) begin
            col_d = 9'd0;
            row_d = row_last ? 9'd0 : (row_q + 9'd1);
`ifdef MAXPOOL_STRIDE1_EN
            if (s1_eff && (row_q != 9'd0)) begin
              state_d = EDGE;
            end else
`endif
            if (row_last) begin
              state_d = IDLE;
              end_d   = 1'b1;
            end
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
`ifdef MAXPOOL_STRIDE1_EN
      EDGE: begin
        // Rightmost window of the row above; row_q has already wrapped on the final row.
        out_valid_d = 1'b1;
        out_data_d  = smax(left_q, prev_q);
        state_d     = (row_q == 9'd0) ? FLUSH : RUN;
      end
      FLUSH: begin
        out_valid_d = 1'b1;
        out_data_d  = smax(lb[col_q[AW-1:0]], lb[flush_idx[AW-1:0]]);
        if (col_last) begin
          col_d   = 9'd0;
          state_d = IDLE;
          end_d   = 1'b1;
        end else begin
          col_d = col_q + 9'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= 9'd0;
      col_q       <= 9'd0;
      n_q         <= 9'd0;
      mode_q      <= 1'b0;
      prev_q      <= '0;
      left_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef MAXPOOL_STRIDE1_EN
      s1_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      n_q         <= n_d;
      mode_q      <= mode_d;
      prev_q      <= prev_d;
      left_q      <= left_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      end_q       <= end_d;
      done_q      <= end_q;
`ifdef MAXPOOL_STRIDE1_EN
      s1_q        <= s1_d;
`endif
    end
  end

  // Line buffer is left unreset; every slot is rewritten before a window reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[col_q[AW-1:0]] <= in_data;
    end
  end

  assign in_ready    = (state_q == RUN);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Randomized bench for maxpool_stream: directed planes plus random planes checked
// against a whole-plane pooling model; honours MAXPOOL_STRIDE1_EN like the design.
module tb_maxpool_stream;
  localparam int DW   = 16;
  localparam int MAXN = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [8:0]    ofm_size_conv = 9'd0;
  logic          maxpool_mode = 1'b0;
  logic [1:0]    maxpool_stride = 2'd0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          done;
  logic [1:0]    dbg_state;

  maxpool_stream #(.DATA_WIDTH(DW), .MAX_ROW_SIZE(416)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ofm_size_conv(ofm_size_conv),
    .maxpool_mode(maxpool_mode), .maxpool_stride(maxpool_stride),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .done(done), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] img [MAXN*MAXN];
  logic [DW-1:0] mon_exp;
  bit            byp_chk = 1'b0;
  bit            hs_prev = 1'b0;
  bit            ov_prev = 1'b0;
  int            done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", tag, got, want);
  endtask

  function automatic logic [DW-1:0] tmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic bit is_s1(input bit mode, input logic [1:0] stride);
`ifdef MAXPOOL_STRIDE1_EN
    return mode && (stride == 2'd1);
`else
    return 1'b0;
`endif
  endfunction

  // reference model: whole-plane pooling, row-major
  task automatic model(input int n, input bit mode, input logic [1:0] stride);
    logic [DW-1:0] m;
    if (!mode) begin
      for (int i = 0; i < n*n; i++) exp_q.push_back(img[i]);
    end else if (is_s1(mode, stride)) begin
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          m = img[r*n+c];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              m = tmax(m, img[((r+dr > n-1) ? n-1 : r+dr)*n + ((c+dc > n-1) ? n-1 : c+dc)]);
          exp_q.push_back(m);
        end
    end else begin
      for (int r = 0; r < n/2; r++)
        for (int c = 0; c < n/2; c++) begin
          m = tmax(tmax(img[(2*r)*n+2*c], img[(2*r)*n+2*c+1]),
                   tmax(img[(2*r+1)*n+2*c], img[(2*r+1)*n+2*c+1]));
          exp_q.push_back(m);
        end
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("extra_out", 32'd1, 32'd0);
        else begin
          mon_exp = exp_q.pop_front();
          check("out_data", {16'b0, out_data}, {16'b0, mon_exp});
        end
      end
      if (byp_chk && hs_prev) check("byp_latency", 32'(out_valid), 32'd1);
      if (done) begin
        done_cnt++;
        check("done_q_empty", 32'(exp_q.size()), 32'd0);
        check("done_after_ov", 32'(ov_prev), 32'd1);
      end
      hs_prev <= in_valid && in_ready;
      ov_prev <= out_valid;
    end else begin
      hs_prev <= 1'b0;
      ov_prev <= 1'b0;
    end
  end

  // driver: one full plane with random valid gaps, ignored starts and config noise
  task automatic run_plane(input int n, input bit mode, input logic [1:0] stride, input bit use_model);
    int idx, low, guard;
    bit hs;
    if (use_model) model(n, mode, stride);
    byp_chk  = !mode;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; ofm_size_conv = 9'(n); maxpool_mode = mode; maxpool_stride = stride;
    @(posedge clk); #1;
    start = 1'b0;
    ofm_size_conv  = 9'($urandom_range(0, 511));
    maxpool_mode   = 1'($urandom_range(0, 1));
    maxpool_stride = 2'($urandom_range(0, 3));
    idx = 0; low = 0; guard = 0;
    while (idx < n*n && guard < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = img[idx];
      start    = ($urandom_range(0, 7) == 0);
      hs = in_valid && in_ready;
      if (!in_ready) low++;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("plane_accepted", 32'(idx), 32'(n*n));
    check("ready_low_cycles", 32'(low), is_s1(mode, stride) ? 32'(n-2) : 32'd0);
    guard = 0;
    while (done_cnt == 0 && guard < 4*n+20) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd0);
    byp_chk = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_ramp(input int n);
    for (int i = 0; i < n*n; i++) img[i] = DW'(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    bit mode;
    logic [1:0] stride;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    load_ramp(4);
    run_plane(4, 1'b0, 2'd2, 1'b1);

    load_ramp(4);
    exp_q.push_back(16'd5); exp_q.push_back(16'd7);
    exp_q.push_back(16'd13); exp_q.push_back(16'd15);
    run_plane(4, 1'b1, 2'd2, 1'b0);

    img[0] = -16'sd3; img[1] = -16'sd1; img[2] = -16'sd7; img[3] = -16'sd2;
    exp_q.push_back(-16'sd1);
    run_plane(2, 1'b1, 2'd2, 1'b0);

`ifdef MAXPOOL_STRIDE1_EN
    load_ramp(3);
    exp_q.push_back(16'd4); exp_q.push_back(16'd5); exp_q.push_back(16'd5);
    exp_q.push_back(16'd7); exp_q.push_back(16'd8); exp_q.push_back(16'd8);
    exp_q.push_back(16'd7); exp_q.push_back(16'd8); exp_q.push_back(16'd8);
    run_plane(3, 1'b1, 2'd1, 1'b0);
`else
    load_ramp(4);
    exp_q.push_back(16'd5); exp_q.push_back(16'd7);
    exp_q.push_back(16'd13); exp_q.push_back(16'd15);
    run_plane(4, 1'b1, 2'd1, 1'b0);
`endif

    // reset in the middle of a stride-2 plane
    load_ramp(4);
    @(posedge clk); #1;
    start = 1'b1; ofm_size_conv = 9'd4; maxpool_mode = 1'b1; maxpool_stride = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (cnt < 5) begin
      in_valid = 1'b1;
      in_data  = img[cnt];
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(16'd5); exp_q.push_back(16'd7);
    exp_q.push_back(16'd13); exp_q.push_back(16'd15);
    run_plane(4, 1'b1, 2'd2, 1'b0);

    for (int i = 0; i < 4; i++) img[i] = DW'($urandom);
    run_plane(2, 1'b1, 2'd1, 1'b1);

    for (int p = 0; p < 14; p++) begin
      n      = $urandom_range(2, MAXN);
      mode   = ($urandom_range(0, 3) != 0);
      stride = 2'($urandom_range(0, 3));
      if (mode && !is_s1(mode, stride) && (n % 2 == 1)) n = n + 1;
      for (int i = 0; i < n*n; i++) img[i] = DW'($urandom);
      run_plane(n, mode, stride, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
